// File: rtl/freq_div_pkg.sv
// Shared types and constants for the programmable frequency divider.
// Holds the FSM state encoding, the divisor floor and the output-mode encodings.
package freq_div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/prog_freq_divider.sv
// Programmable clock divider: square-wave or single-cycle-pulse output with a period of N clocks.
// New divisor/mode settings are staged and only take effect on a period boundary or while idle.
module prog_freq_divider
    import freq_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic [WIDTH-1:0] Din,
    input  logic             ModeIn,
    input  logic             ConfigDiv,
    input  logic             Enable,
    output logic             ClkOut,
    output logic             Tick,
    output logic             ConfigAck,
    output logic             Active
);

    localparam logic [WIDTH-1:0] MIN_DIV_W     = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);

    state_e           state_q;
    logic [WIDTH-1:0] div_q;
    logic             mode_q;
    logic [WIDTH-1:0] pend_div_q;
    logic             pend_mode_q;
    logic             pending_q;
    logic [WIDTH-1:0] cnt_q;
    logic             clk_out_q;
    logic             tick_q;
    logic             ack_q;

    logic [WIDTH-1:0] n_eff;
    logic [WIDTH-1:0] cnt_d;
    logic             at_wrap;
    logic             apply_cfg;

    // Output level for a given position in the period. Square mode keeps the
    // longer half high, so odd divisors give ceil(N/2) high cycles.
    function automatic logic level_at(input logic [WIDTH-1:0] cnt,
                                      input logic [WIDTH-1:0] n,
                                      input logic             mode);
        if (mode == MODE_PULSE) begin
            return (cnt == '0);
        end
        return (cnt < (n - (n >> 1)));
    endfunction

    always_comb begin
        n_eff     = (div_q < MIN_DIV_W) ? MIN_DIV_W : div_q;
        cnt_d     = cnt_q + WIDTH'(1);
        at_wrap   = (cnt_q == (n_eff - WIDTH'(1)));
        // Staged settings land only where a fresh period begins: any idle edge,
        // or the wrap edge of a running period that is not being stopped.
        apply_cfg = pending_q && ((state_q == IDLE) || (Enable && at_wrap));
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            div_q       <= DEFAULT_DIV_W;
            mode_q      <= MODE_SQUARE;
            pend_div_q  <= '0;
            pend_mode_q <= MODE_SQUARE;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            ack_q <= apply_cfg;

            if (apply_cfg) begin
                div_q     <= pend_div_q;
                mode_q    <= pend_mode_q;
                pending_q <= 1'b0;
            end
            // A strobe on the apply edge stages a new value after the old one
            // has been consumed, so it waits for the following boundary.
            if (ConfigDiv) begin
                pend_div_q  <= Din;
                pend_mode_q <= ModeIn;
                pending_q   <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (Enable) begin
                        state_q   <= RUN;
                        tick_q    <= 1'b1;
                        clk_out_q <= 1'b1;
                    end else begin
                        tick_q    <= 1'b0;
                        clk_out_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (!Enable) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        tick_q    <= 1'b0;
                        clk_out_q <= 1'b0;
                    end else if (at_wrap) begin
                        cnt_q     <= '0;
                        tick_q    <= 1'b1;
                        clk_out_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_d;
                        tick_q    <= 1'b0;
                        clk_out_q <= level_at(cnt_d, n_eff, mode_q);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    tick_q    <= 1'b0;
                    clk_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign ClkOut    = clk_out_q;
    assign Tick      = tick_q;
    assign ConfigAck = ack_q;
    assign Active    = (state_q == RUN);

endmodule
